// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky TRAP on illegal opcodes.
// Drives ALU op, datapath mux selects and write enables; waits indefinitely on memory readies.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic [2:0] state,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   legal;

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
      default:                                                  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_op    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_I: begin
            alu_op    = 2'b11;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_op   = 2'b01;
            pc_write = br_taken;
            pc_src   = 2'd1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
            state_d  = S_WB;
          end
          OP_JALR: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            state_d   = S_WB;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        // address computation held so the request stays stable through waits
        dmem_req  = 1'b1;
        alu_src_b = 1'b1;
        dmem_we   = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (opcode)
          OP_R:             alu_op = 2'b10;
          OP_I: begin
            alu_op    = 2'b11;
            alu_src_b = 1'b1;
          end
          OP_LOAD:          wb_sel = 2'd1;
          OP_JAL, OP_JALR:  wb_sel = 2'd2;
          default:          wb_sel = 2'd0;
        endcase
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_FETCH;
    endcase

    // reset abandons whatever is in flight and silences every output
    if (reset) begin
      state_d   = S_FETCH;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      alu_op    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors and per-instruction
// latencies are queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       br_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic [2:0] state;
  logic       imem_req, ir_write, pc_write, alu_src_a, alu_src_b;
  logic       dmem_req, dmem_we, reg_write, retire, illegal;
  logic [1:0] pc_src, alu_op, wb_sel;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          lat_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] v(input int st, iq, irw, pcw, ps, ao, sa, sb,
                                    dq, dw, rw, ws, rt, il);
    return {st[2:0], iq[0], irw[0], pcw[0], ps[1:0], ao[1:0], sa[0], sb[0],
            dq[0], dw[0], rw[0], ws[1:0], rt[0], il[0]};
  endfunction

  logic [18:0] ZERO, F_WAIT, F_RDY, DEC;

  task automatic step(input logic rst, ir, dr, bt, input logic [18:0] e, input string nm);
    reset = rst; imem_ready = ir; dmem_ready = dr; br_taken = bt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // per-cycle output monitor plus retire-to-retire latency check
  initial begin : monitor
    logic [18:0] act, e;
    string       nm;
    int          cnt;
    int          want;
    cnt = 0;
    forever begin
      @(negedge clk);
      act = {state, imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
             dmem_req, dmem_we, reg_write, wb_sel, retire, illegal};
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b expected %b (st,iq,irw,pcw,ps,ao,a,b,dq,dw,rw,ws,rt,il)",
                   nm, act, e);
        end
      end
      if (reset) cnt = 0;
      else begin
        cnt++;
        if (retire === 1'b1) begin
          checks++;
          if (lat_q.size() == 0) begin
            errors++;
            $display("FAIL latency: unexpected retire after %0d cycles, none required", cnt);
          end else begin
            want = lat_q.pop_front();
            if (cnt != want) begin
              errors++;
              $display("FAIL latency: got %0d cycles, required %0d", cnt, want);
            end
          end
          cnt = 0;
        end
      end
    end
  end

  initial begin
    ZERO   = v(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    F_WAIT = v(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    F_RDY  = v(0,1,1,1,0,0,0,0,0,0,0,0,0,0);
    DEC    = v(1,0,0,0,0,0,0,0,0,0,0,0,0,0);

    @(posedge clk); #1;
    step(1, 1, 1, 0, ZERO, "reset0");
    step(1, 1, 1, 0, ZERO, "reset1");

    // R-type add, zero-wait fetch
    opcode = 7'b0110011; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "r_fetch");
    step(0, 1, 1, 0, DEC, "r_decode");
    step(0, 1, 0, 0, v(2,0,0,0,0,2,0,0,0,0,0,0,0,0), "r_exec");
    step(0, 1, 0, 0, v(4,0,0,0,0,2,0,0,0,0,1,0,1,0), "r_wb");

    // LOAD: fetch 2 late, data 3 late
    opcode = 7'b0000011; lat_q.push_back(10);
    step(0, 0, 0, 0, F_WAIT, "ld_fetch_w0");
    step(0, 0, 0, 0, F_WAIT, "ld_fetch_w1");
    step(0, 1, 0, 0, F_RDY, "ld_fetch");
    step(0, 1, 0, 0, DEC, "ld_decode");
    step(0, 1, 0, 0, v(2,0,0,0,0,0,0,1,0,0,0,0,0,0), "ld_exec");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, v(3,0,0,0,0,0,0,1,1,0,0,0,0,0), "ld_mem_wait");
    step(0, 1, 1, 0, v(3,0,0,0,0,0,0,1,1,0,0,0,0,0), "ld_mem");
    step(0, 1, 0, 0, v(4,0,0,0,0,0,0,0,0,0,1,1,1,0), "ld_wb");

    // BRANCH taken then not taken
    opcode = 7'b1100011; lat_q.push_back(3); lat_q.push_back(3);
    step(0, 1, 0, 0, F_RDY, "bt_fetch");
    step(0, 1, 0, 0, DEC, "bt_decode");
    step(0, 1, 0, 1, v(2,0,0,1,1,1,0,0,0,0,0,0,1,0), "bt_exec");
    step(0, 1, 0, 1, F_RDY, "bn_fetch");
    step(0, 1, 0, 1, DEC, "bn_decode");
    step(0, 1, 0, 0, v(2,0,0,0,1,1,0,0,0,0,0,0,1,0), "bn_exec");

    // JALR
    opcode = 7'b1100111; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "jalr_fetch");
    step(0, 1, 0, 0, DEC, "jalr_decode");
    step(0, 1, 0, 0, v(2,0,0,1,2,0,0,1,0,0,0,0,0,0), "jalr_exec");
    step(0, 1, 0, 0, v(4,0,0,0,0,0,0,0,0,0,1,2,1,0), "jalr_wb");

    // I-ALU
    opcode = 7'b0010011; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "i_fetch");
    step(0, 1, 0, 0, DEC, "i_decode");
    step(0, 1, 0, 0, v(2,0,0,0,0,3,0,1,0,0,0,0,0,0), "i_exec");
    step(0, 1, 0, 0, v(4,0,0,0,0,3,0,1,0,0,1,0,1,0), "i_wb");

    // JAL
    opcode = 7'b1101111; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "jal_fetch");
    step(0, 1, 0, 0, DEC, "jal_decode");
    step(0, 1, 0, 0, v(2,0,0,1,1,0,0,0,0,0,0,0,0,0), "jal_exec");
    step(0, 1, 0, 0, v(4,0,0,0,0,0,0,0,0,0,1,2,1,0), "jal_wb");

    // STORE zero-wait
    opcode = 7'b0100011; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "st_fetch");
    step(0, 1, 1, 0, DEC, "st_decode");
    step(0, 1, 1, 0, v(2,0,0,0,0,0,0,1,0,0,0,0,0,0), "st_exec");
    step(0, 1, 1, 0, v(3,0,0,0,0,0,0,1,1,1,0,0,1,0), "st_mem");

    // illegal opcode parks in TRAP until reset
    opcode = 7'b0000000;
    step(0, 1, 0, 0, F_RDY, "ill_fetch");
    step(0, 1, 0, 0, DEC, "ill_decode");
    for (int i = 0; i < 20; i++)
      step(0, 1, 1, 0, v(7,0,0,0,0,0,0,0,0,0,0,0,0,1), "trap");
    step(1, 1, 0, 0, ZERO, "trap_reset");

    // STORE abandoned by reset during a MEM wait
    opcode = 7'b0100011;
    step(0, 1, 0, 0, F_RDY, "st2_fetch");
    step(0, 1, 0, 0, DEC, "st2_decode");
    step(0, 1, 0, 0, v(2,0,0,0,0,0,0,1,0,0,0,0,0,0), "st2_exec");
    step(0, 1, 0, 0, v(3,0,0,0,0,0,0,1,1,1,0,0,0,0), "st2_mem_wait0");
    step(0, 1, 0, 0, v(3,0,0,0,0,0,0,1,1,1,0,0,0,0), "st2_mem_wait1");
    step(1, 1, 1, 0, ZERO, "st2_reset");

    // fetch after abandoned store proceeds normally
    opcode = 7'b0110011; lat_q.push_back(4);
    step(0, 1, 0, 0, F_RDY, "r2_fetch");
    step(0, 1, 0, 0, DEC, "r2_decode");
    step(0, 1, 0, 0, v(2,0,0,0,0,2,0,0,0,0,0,0,0,0), "r2_exec");
    step(0, 0, 0, 0, v(4,0,0,0,0,2,0,0,0,0,1,0,1,0), "r2_wb");
    step(0, 0, 0, 0, F_WAIT, "r2_idle");

    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d vectors and %0d latencies left, required 0 and 0",
               exp_q.size(), lat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core datapath. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the 2-bit `alu_op` consumed by the ALU function decoder, plus the mux selects and write enables of the shared ALU/PC/register-file/memory datapath. It handshakes with instruction and data memory, waiting any number of cycles for a ready. Illegal opcodes park the core in a sticky TRAP state.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: IR[6:0]; valid and stable from DECODE until the instruction retires.
- `br_taken` in 1: datapath branch-compare result, valid in EXEC.
- `imem_ready` in 1: instruction-fetch completion.
- `dmem_ready` in 1: data-access completion.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- `imem_req` out 1: instruction-fetch request.
- `ir_write` out 1: latch fetched word into IR and old PC.
- `pc_write` out 1: PC update enable.
- `pc_src` out 2: 0 = PC+4, 1 = branch/JAL target, 2 = ALU result & ~1 (JALR).
- `alu_op` out 2: 00 add, 01 branch, 10 R-type, 11 I-type.
- `alu_src_a` out 1: 0 = rs1, 1 = old PC.
- `alu_src_b` out 1: 0 = rs2, 1 = immediate.
- `dmem_req` out 1: data-access request.
- `dmem_we` out 1: data write enable.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = old PC+4.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` out 1: high while in TRAP.

## Operation
- All outputs are Moore: decoded from the registered state and the opcode, except the handshake-qualified strobes `ir_write`, `pc_write`, `retire` and `reg_write`.
- Any output not listed for a state is 0.
- FETCH:
  - `imem_req`=1 every cycle until `imem_ready`.
  - In the `imem_ready` cycle: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE, by opcode:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111 → EXEC.
  - Any other opcode → TRAP.
- EXEC, by opcode:
  - R (0110011): `alu_op`=10, a=rs1, b=rs2 → WB.
  - I-ALU (0010011): `alu_op`=11, b=imm → WB.
  - LOAD (0000011): `alu_op`=00, b=imm → MEM.
  - STORE (0100011): `alu_op`=00, b=imm → MEM.
  - BRANCH (1100011): `alu_op`=01, a=rs1, b=rs2. `pc_write`=`br_taken`, `pc_src`=1, `retire`=1 → FETCH.
  - JAL (1101111): `alu_op`=00, `pc_write`=1, `pc_src`=1 → WB.
  - JALR (1100111): `alu_op`=00, a=rs1, b=imm, `pc_write`=1, `pc_src`=2 → WB.
- MEM:
  - Hold `dmem_req`=1 and `alu_op`=00 with b=imm (address stable); `dmem_we`=1 for STORE.
  - Stay in MEM until `dmem_ready`.
  - On ready: LOAD → WB; STORE asserts `retire` → FETCH.
- WB:
  - `reg_write`=1 and `retire`=1, then → FETCH.
  - `wb_sel`: 0 for R and I-ALU, 1 for LOAD, 2 for JAL and JALR.
  - R and I-ALU keep their EXEC `alu_op` and source selects so the ALU result is stable.
- TRAP:
  - `illegal`=1, all other outputs 0, no requests issued.
  - Only `reset` leaves TRAP.
- A ready that arrives while no request is outstanding is ignored.

## Timing
- Reset has priority. In the clock after `reset` is sampled high: state=FETCH, `illegal`=0, `retire`=0.
- While `reset` is high, all outputs are forced to 0, including `imem_req`. `imem_req` rises in the first cycle after `reset` falls.
- Reset asserted mid-instruction (any state, including while a request is pending): the instruction is abandoned, with no `retire` and no write enables in the following cycle.
- Cycle counts with zero-wait memory (ready in the request's first cycle):
  - Branch: 3.
  - R, I-ALU, JAL, JALR, STORE: 4.
  - LOAD: 5.
- Each memory wait cycle adds exactly one cycle. Requests stay asserted and all selects stay stable through waits.
- `retire` fires exactly once per legal instruction, never in TRAP.

## Test plan
- Reset then R-type `add` (opcode 0110011), `imem_ready` held high:
  - states 0,1,2,4,0;
  - `alu_op`=10 in EXEC and WB;
  - `reg_write` and `retire` in cycle 4 only.
- LOAD with `imem_ready` late by 2 cycles and `dmem_ready` late by 3:
  - FETCH lasts 3 cycles, MEM lasts 4, total 10 cycles;
  - `wb_sel`=1 in WB;
  - `dmem_we`=0 throughout.
- BRANCH with `br_taken`=1, then BRANCH with `br_taken`=0:
  - 3 cycles each;
  - `pc_write` in EXEC is 1 then 0;
  - `pc_src`=1; `reg_write` never set.
- JALR:
  - EXEC shows `pc_src`=2 and `pc_write`=1;
  - WB shows `wb_sel`=2 and `reg_write`=1.
- Opcode 0000000 fetched:
  - DECODE → TRAP; `illegal`=1 for 20 cycles with no `imem_req`;
  - `reset` returns the block to FETCH with `illegal`=0.
- STORE with `reset` pulsed during a MEM wait:
  - next state FETCH, `dmem_req` drops, no `retire`;
  - the next fetch proceeds normally.
